pcm_dac_mc: RTL and testbench

//  Parametrised multi-channel PCM-to-1-bit sigma-delta DAC; next generation of the sound output path.

---
 rtl/pcm_dac_mc.sv | 174 +++++++++++++++++
 tb/tb_pcm_dac_mc.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_dac_mc.sv
// pcm_dac_mc: multi-channel PCM to 1-bit first-order sigma-delta DAC.
//   A frame FIFO holds one sample per channel. Frames are popped at a
//   programmable sample rate from a phase-accumulator timer. Each channel
//   drives its own first-order modulator, stepped every MOD_DIV clocks.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enable           1 = play; 0 = modulators fed midscale, timer and pops frozen
//   signed_in        input samples are two's complement (else offset binary)
//   rate_inc         sample-timer increment, Fs = Fclk*rate_inc/2^RATE_W
//   wr_en, wr_data   frame push; channel c at [c*WIDTH +: WIDTH]
//   wr_ready         FIFO not full (registered)
//   fifo_level       frames held, 0..DEPTH (registered)
//   irq              enable && fifo_level <= DEPTH/2 (registered)
//   clr_status       clears sticky overflow/underrun (a same-cycle event wins)
//   overflow         sticky: push attempted while full
//   underrun         sticky: sample tick with FIFO empty
//   audio_out        per-channel 1-bit modulator outputs (registered)
module pcm_dac_mc #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int RATE_W   = 16,
    parameter int MOD_DIV  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      signed_in,
    input  logic [RATE_W-1:0]         rate_inc,
    input  logic                      wr_en,
    input  logic [CHANNELS*WIDTH-1:0] wr_data,
    output logic                      wr_ready,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      irq,
    input  logic                      clr_status,
    output logic                      overflow,
    output logic                      underrun,
    output logic [CHANNELS-1:0]       audio_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (MOD_DIV > 1) ? $clog2(MOD_DIV) : 1;
    localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CHANNELS*WIDTH-1:0]          mem_q [DEPTH];
    logic [AW-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                      level_q, level_d;
    logic                               wr_ready_q, wr_ready_d;
    logic                               irq_q, irq_d;
    logic                               ovf_q, ovf_d;
    logic                               und_q, und_d;
    logic [RATE_W-1:0]                  phase_q, phase_d;
    logic [CHANNELS-1:0][WIDTH-1:0]     active_q, active_d;
    logic [CHANNELS-1:0][WIDTH-1:0]     acc_q, acc_d;
    logic [CHANNELS-1:0]                audio_q, audio_d;
    logic [CW-1:0]                      cnt_q, cnt_d;

    logic [CHANNELS*WIDTH-1:0]          conv_frame;
    logic [CHANNELS*WIDTH-1:0]          rd_frame;
    logic [RATE_W:0]                    phase_sum;
    logic                               push, pop, tick, empty;
    logic                               ovf_evt, und_evt, strobe;
    logic [CHANNELS-1:0][WIDTH-1:0]     mod_x;
    logic [CHANNELS-1:0][WIDTH:0]       mod_sum;

    // Two's complement -> offset binary is just an MSB flip per channel.
    always_comb begin
        conv_frame = wr_data;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            conv_frame[c*WIDTH + WIDTH - 1] = wr_data[c*WIDTH + WIDTH - 1] ^ signed_in;
        end
    end

    assign rd_frame = mem_q[rd_ptr_q];

    // FIFO, sample timer and status flags.
    always_comb begin
        push      = wr_en && wr_ready_q;
        ovf_evt   = wr_en && !wr_ready_q;
        phase_sum = {1'b0, phase_q} + {1'b0, rate_inc};
        tick      = enable && phase_sum[RATE_W];
        phase_d   = enable ? phase_sum[RATE_W-1:0] : phase_q;
        empty     = (level_q == '0);
        // An empty FIFO cannot pop this cycle even if a push lands alongside.
        pop       = tick && !empty;
        und_evt   = tick && empty;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        wr_ready_d = (level_d != LW'(DEPTH));
        irq_d      = enable && (level_d <= LW'(DEPTH / 2));

        ovf_d = ovf_evt ? 1'b1 : (clr_status ? 1'b0 : ovf_q);
        und_d = und_evt ? 1'b1 : (clr_status ? 1'b0 : und_q);

        active_d = active_q;
        if (pop) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                active_d[c] = rd_frame[c*WIDTH +: WIDTH];
            end
        end
    end

    // Modulator strobe and per-channel first-order accumulators.
    always_comb begin
        strobe  = (cnt_q == CW'(MOD_DIV - 1));
        cnt_d   = strobe ? '0 : cnt_q + CW'(1);
        acc_d   = acc_q;
        audio_d = audio_q;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            mod_x[c]   = enable ? active_q[c] : MIDSCALE;
            mod_sum[c] = {1'b0, acc_q[c]} + {1'b0, mod_x[c]};
            if (strobe) begin
                acc_d[c]   = mod_sum[c][WIDTH-1:0];
                audio_d[c] = mod_sum[c][WIDTH];
            end
        end
    end

    // Frame storage needs no reset: pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= conv_frame;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wr_ready_q <= 1'b1;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            und_q      <= 1'b0;
            phase_q    <= '0;
            active_q   <= {CHANNELS{MIDSCALE}};
            acc_q      <= '0;
            audio_q    <= '0;
            cnt_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wr_ready_q <= wr_ready_d;
            irq_q      <= irq_d;
            ovf_q      <= ovf_d;
            und_q      <= und_d;
            phase_q    <= phase_d;
            active_q   <= active_d;
            acc_q      <= acc_d;
            audio_q    <= audio_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign fifo_level = level_q;
    assign irq        = irq_q;
    assign overflow   = ovf_q;
    assign underrun   = und_q;
    assign audio_out  = audio_q;

endmodule

// File: tb/tb_pcm_dac_mc.sv
// tb_pcm_dac_mc: self-checking bench for pcm_dac_mc (2 channels, 8-bit samples,
// 4-deep FIFO, 16-bit rate accumulator, modulator step every 2 clocks).
// Expected stored samples are queued at push time and compared against the
// measured ones-density of audio_out when the frame is played.
module tb_pcm_dac_mc;

    localparam int CH    = 2;
    localparam int W     = 8;
    localparam int DEP   = 4;
    localparam int RW    = 16;
    localparam int MDIV  = 2;
    localparam int WIN   = (1 << W) * MDIV;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              signed_in;
    logic [RW-1:0]     rate_inc;
    logic              wr_en;
    logic [CH*W-1:0]   wr_data;
    logic              wr_ready;
    logic [2:0]        fifo_level;
    logic              irq;
    logic              clr_status;
    logic              overflow;
    logic              underrun;
    logic [CH-1:0]     audio_out;

    typedef struct {
        int c0;
        int c1;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pcm_dac_mc #(
        .CHANNELS(CH),
        .WIDTH   (W),
        .DEPTH   (DEP),
        .RATE_W  (RW),
        .MOD_DIV (MDIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .signed_in (signed_in),
        .rate_inc  (rate_inc),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .fifo_level(fifo_level),
        .irq       (irq),
        .clr_status(clr_status),
        .overflow  (overflow),
        .underrun  (underrun),
        .audio_out (audio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int conv(input logic [W-1:0] d, input logic sgn);
        logic [W-1:0] u;
        u = sgn ? {~d[W-1], d[W-2:0]} : d;
        return int'(u);
    endfunction

    // Push one frame; the expected stored values are queued only if accepted.
    task automatic push_frame(input logic [W-1:0] d1, input logic [W-1:0] d0);
        exp_t e;
        if (wr_ready) begin
            e.c0 = conv(d0, signed_in);
            e.c1 = conv(d1, signed_in);
            sb.push_back(e);
        end
        wr_en   = 1'b1;
        wr_data = {d1, d0};
        step();
        wr_en   = 1'b0;
    endtask

    task automatic measure(output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < WIN; i++) begin
            step();
            n0 += int'(audio_out[0]);
            n1 += int'(audio_out[1]);
        end
    endtask

    // Let the timer pop exactly one frame, then check its ones-density.
    task automatic play_one(input string tag);
        int   lvl0;
        int   got;
        int   n0, n1;
        exp_t e;
        lvl0     = int'(fifo_level);
        got      = 0;
        rate_inc = 16'h4000;
        for (int i = 0; i < 40 && got == 0; i++) begin
            step();
            if (int'(fifo_level) != lvl0) got = 1;
        end
        rate_inc = '0;
        check({tag, "_pop"}, got, 1);
        check({tag, "_lvl"}, int'(fifo_level), lvl0 - 1);
        step(8);
        measure(n0, n1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_ch0"}, n0, MDIV * e.c0);
            check({tag, "_ch1"}, n1, MDIV * e.c1);
        end else begin
            check({tag, "_sb_empty"}, 0, 1);
        end
    endtask

    initial begin
        int   n0, n1;
        exp_t e;

        rst_n      = 1'b0;
        enable     = 1'b0;
        signed_in  = 1'b0;
        rate_inc   = '0;
        wr_en      = 1'b0;
        wr_data    = '0;
        clr_status = 1'b0;
        #23;
        check("rst_level", int'(fifo_level), 0);
        check("rst_ready", int'(wr_ready), 1);
        check("rst_irq",   int'(irq), 0);
        check("rst_ovf",   int'(overflow), 0);
        check("rst_und",   int'(underrun), 0);
        check("rst_audio", int'(audio_out), 0);
        step();
        rst_n = 1'b1;
        step(2);

        // Fill while muted, overflow, status clear behaviour.
        push_frame(8'hFF, 8'h40);
        push_frame(8'h01, 8'h80);
        push_frame(8'hC3, 8'h00);
        push_frame(8'h10, 8'h7F);
        check("full_level", int'(fifo_level), 4);
        check("full_ready", int'(wr_ready), 0);
        check("full_irq",   int'(irq), 0);
        push_frame(8'h55, 8'h55);
        check("ovf_set",    int'(overflow), 1);
        check("ovf_level",  int'(fifo_level), 4);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("ovf_clr",    int'(overflow), 0);
        wr_en      = 1'b1;
        clr_status = 1'b1;
        step();
        wr_en      = 1'b0;
        clr_status = 1'b0;
        check("ovf_wins",   int'(overflow), 1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("ovf_clr2",   int'(overflow), 0);

        // Play the four frames.
        enable = 1'b1;
        step(2);
        check("irq_full_en", int'(irq), 0);
        play_one("f0");
        check("ready_after_pop", int'(wr_ready), 1);
        play_one("f1");
        check("irq_half", int'(irq), 1);
        play_one("f2");
        play_one("f3");
        check("drain_level", int'(fifo_level), 0);
        check("drain_und",   int'(underrun), 0);

        // Signed input conversion.
        signed_in = 1'b1;
        push_frame(8'h80, 8'h00);
        push_frame(8'h7F, 8'hFF);
        signed_in = 1'b0;
        play_one("s0");
        play_one("s1");

        // Tick timing, underrun, same-cycle push/clear/tick on empty.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        push_frame(8'h11, 8'h22);
        push_frame(8'h33, 8'h44);
        rate_inc = 16'h4000;
        step(3);
        check("t4_clk3_lvl", int'(fifo_level), 2);
        step();
        check("t4_clk4_lvl", int'(fifo_level), 1);
        void'(sb.pop_front());
        step(4);
        check("t4_clk8_lvl", int'(fifo_level), 0);
        step(3);
        check("t4_clk11_und", int'(underrun), 0);
        step();
        check("t4_clk12_und", int'(underrun), 1);
        step(3);
        wr_en      = 1'b1;
        wr_data    = {8'h55, 8'h66};
        clr_status = 1'b1;
        e.c0 = 'h66;
        e.c1 = 'h55;
        sb.push_back(e);
        step();
        wr_en      = 1'b0;
        clr_status = 1'b0;
        rate_inc   = '0;
        check("t4_clk16_und", int'(underrun), 1);
        check("t4_clk16_lvl", int'(fifo_level), 1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("t4_und_clr", int'(underrun), 0);
        step(8);
        measure(n0, n1);
        e = sb.pop_front();
        check("t4_hold_ch0", n0, MDIV * e.c0);
        check("t4_hold_ch1", n1, MDIV * e.c1);

        // Disable mid-stream: frozen FIFO, muted output, resume.
        push_frame(8'hFF, 8'hFF);
        enable   = 1'b0;
        rate_inc = 16'h4000;
        step(20);
        check("mute_level", int'(fifo_level), 2);
        check("mute_irq",   int'(irq), 0);
        step(8);
        measure(n0, n1);
        check("mute_ch0", n0, MDIV * 128);
        check("mute_ch1", n1, MDIV * 128);
        rate_inc = '0;
        enable   = 1'b1;
        step(2);
        check("resume_irq", int'(irq), 1);
        play_one("r0");
        play_one("r1");

        // Asynchronous reset with frames queued.
        rate_inc = 16'h4000;
        step(6);
        rate_inc = '0;
        check("t6_und", int'(underrun), 1);
        push_frame(8'h01, 8'h02);
        push_frame(8'h03, 8'h04);
        push_frame(8'h05, 8'h06);
        check("t6_level", int'(fifo_level), 3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_level", int'(fifo_level), 0);
        check("arst_ready", int'(wr_ready), 1);
        check("arst_und",   int'(underrun), 0);
        check("arst_irq",   int'(irq), 0);
        check("arst_audio", int'(audio_out), 0);
        sb.delete();
        #1;
        rst_n = 1'b1;
        step(2);
        check("post_rst_level", int'(fifo_level), 0);
        step(8);
        measure(n0, n1);
        check("post_rst_ch0", n0, MDIV * 128);
        check("post_rst_ch1", n1, MDIV * 128);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
